// File: rtl/noc_pkg.sv
// Shared flit definitions for the tree-router merge stage.
// Address bits sit at the top of every flit and are carried through untouched.
package noc_pkg;

   localparam int unsigned FLIT_W   = 9;
   localparam int unsigned ADDR_MSB = 8;
   localparam int unsigned ADDR_LSB = 5;
   localparam int unsigned ADDR_W   = 4;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic {
      SRC_IN0 = 1'b0,
      SRC_IN1 = 1'b1
   } src_e;

endpackage

// File: rtl/noc_merge_arb2_if.sv
// Handshake bundle for the 2:1 merge stage: two flit inputs, one merged output, counters.
// slave is the merge stage's view, master is the view of whatever drives and consumes it.
interface noc_merge_arb2_if
   import noc_pkg::*;
#(
   parameter int unsigned W    = FLIT_W,
   parameter int unsigned CNTW = 16
);

   logic [W-1:0]    in0_data;
   logic            in0_valid;
   logic            in0_ready;
   logic [W-1:0]    in1_data;
   logic            in1_valid;
   logic            in1_ready;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_src;
   logic [CNTW-1:0] cnt0;
   logic [CNTW-1:0] cnt1;

   modport slave (
      input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
      output in0_ready, in1_ready, out_data, out_valid, out_src, cnt0, cnt1
   );

   modport master (
      output in0_data, in0_valid, in1_data, in1_valid, out_ready,
      input  in0_ready, in1_ready, out_data, out_valid, out_src, cnt0, cnt1
   );

endinterface

// File: rtl/noc_fifo.sv
// Small pointer-based flit FIFO; the extra pointer MSB tells full from empty.
// The caller never pushes when full nor pops when empty.
module noc_fifo #(
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: nothing is read until the pointers say it was written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/noc_merge_arb2.sv
// Clocked 2:1 flit merge: per-input FIFOs, round-robin grant into a registered output stage,
// and per-input forwarded-flit counters.
module noc_merge_arb2
   import noc_pkg::*;
#(
   parameter int unsigned W     = FLIT_W,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNTW  = 16
) (
   input logic             clk,
   input logic             rst,
   noc_merge_arb2_if.slave bus
);

   localparam logic [CNTW-1:0] CNT_ONE = 1;

   logic [W-1:0]    head0, head1;
   logic            empty0, empty1, full0, full1;
   logic            push0, push1, pop0, pop1;
   logic            load, grant_en;
   src_e            grant;
   src_e            rr_ptr_q, rr_ptr_d;
   src_e            out_src_q, out_src_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [CNTW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // Ready comes only from registered occupancy, so there is no valid->ready path.
   assign push0 = bus.in0_valid && !full0;
   assign push1 = bus.in1_valid && !full1;

   noc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push0),
      .pop   (pop0),
      .din   (bus.in0_data),
      .dout  (head0),
      .empty (empty0),
      .full  (full0)
   );

   noc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push1),
      .pop   (pop1),
      .din   (bus.in1_data),
      .dout  (head1),
      .empty (empty1),
      .full  (full1)
   );

   always_comb begin
      load     = !out_valid_q || bus.out_ready;
      grant_en = load && !(empty0 && empty1);
      if (!empty0 && !empty1) grant = rr_ptr_q;
      else if (!empty0)       grant = SRC_IN0;
      else                    grant = SRC_IN1;
      pop0 = grant_en && (grant == SRC_IN0);
      pop1 = grant_en && (grant == SRC_IN1);

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      if (grant_en) begin
         out_valid_d = 1'b1;
         out_src_d   = grant;
         out_data_d  = (grant == SRC_IN0) ? head0 : head1;
         rr_ptr_d    = (grant == SRC_IN0) ? SRC_IN1 : SRC_IN0;
         if (grant == SRC_IN0) cnt0_d = cnt0_q + CNT_ONE;
         else                  cnt1_d = cnt1_q + CNT_ONE;
      end else if (load) begin
         // Output accepted (or already idle) with nothing queued behind it.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= SRC_IN0;
         rr_ptr_q    <= SRC_IN0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign bus.in0_ready = !full0;
   assign bus.in1_ready = !full1;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.cnt0      = cnt0_q;
   assign bus.cnt1      = cnt1_q;

endmodule
